// File: rtl/tb_stdout_putchar_mux.sv
// Putchar concentrator: per-core character FIFOs drained round-robin onto the stdout write bus.
// Optional trace/overflow messages are enabled with `define TB_STDOUT_MUX_TRACE_EN.
module tb_stdout_putchar_mux #(
  parameter int unsigned NB_CORES   = 4,
  parameter int unsigned CLUSTER_ID = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1A10F000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NB_CORES-1:0]       req_i,
  input  logic [NB_CORES*8-1:0]     char_i,
  output logic [NB_CORES-1:0]       gnt_o,
  output logic                      CSN,
  output logic                      WEN,
  output logic [ADDR_WIDTH-1:0]     ADDR,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   BE
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RR_W  = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam logic [BE_W-1:0] BE_LOW = BE_W'(4'hF);
  localparam logic [ADDR_WIDTH-1:0] CLUSTER_BITS = ADDR_WIDTH'(CLUSTER_ID) << 7;

  logic [7:0]       mem_q    [NB_CORES][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NB_CORES];
  logic [PTR_W-1:0] rd_ptr_q [NB_CORES];
  logic [CNT_W-1:0] cnt_q    [NB_CORES];
  logic [NB_CORES-1:0] full, empty, push, pop;

  logic [RR_W-1:0] rr_q;
  logic [RR_W-1:0] win;
  logic            pop_valid;
  int              idx;

  always_comb begin
    for (int k = 0; k < NB_CORES; k++) begin
      full[k]  = (cnt_q[k] == CNT_W'(FIFO_DEPTH));
      empty[k] = (cnt_q[k] == '0);
      gnt_o[k] = !full[k] && !rst_i;
      push[k]  = req_i[k] && gnt_o[k];
    end
  end

  // Round-robin scan starting at rr_q; the first non-empty FIFO wins.
  always_comb begin
    pop_valid = 1'b0;
    win       = '0;
    idx       = 0;
    for (int i = 0; i < NB_CORES; i++) begin
      idx = (int'(rr_q) + i) % NB_CORES;
      if (!pop_valid && !empty[idx]) begin
        pop_valid = 1'b1;
        win       = RR_W'(idx);
      end
    end
    for (int k = 0; k < NB_CORES; k++) begin
      pop[k] = pop_valid && (int'(win) == k);
    end
  end

  // NOTE: the character storage carries no reset; pointers and counts alone define validity,
  // and leaving the array reset-free lets it map onto plain registers or RAM.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NB_CORES; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= char_i[8*k +: 8];
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every process sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NB_CORES; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int k = 0; k < NB_CORES; k++) begin
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
        if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
        case ({push[k], pop[k]})
          2'b10:   cnt_q[k] <= cnt_q[k] + CNT_W'(1);
          2'b01:   cnt_q[k] <= cnt_q[k] - CNT_W'(1);
          default: cnt_q[k] <= cnt_q[k];
        endcase
      end
      if (pop_valid) begin
        if (int'(win) == NB_CORES - 1) rr_q <= '0;
        else                           rr_q <= win + RR_W'(1);
      end
    end
  end

  // Bus beat registers; address/data/enables hold across idle cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      CSN   <= 1'b1;
      WEN   <= 1'b1;
      ADDR  <= '0;
      WDATA <= '0;
      BE    <= '0;
    end else if (pop_valid) begin
      CSN   <= 1'b0;
      WEN   <= 1'b0;
      ADDR  <= BASE_ADDR | CLUSTER_BITS | (ADDR_WIDTH'(win) << 3);
      WDATA <= DATA_WIDTH'(mem_q[win][rd_ptr_q[win]]);
      BE    <= BE_LOW;
    end else begin
      CSN   <= 1'b1;
      WEN   <= 1'b1;
    end
  end

`ifdef TB_STDOUT_MUX_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i && pop_valid)
      $display("%0t [PUTCHAR-CL%0d_PE%0d] 0x%02h", $time, CLUSTER_ID, win, mem_q[win][rd_ptr_q[win]]);
    for (int k = 0; k < NB_CORES; k++) begin
      if (!rst_i && req_i[k] && full[k])
        $warning("putchar core %0d: request refused, FIFO full", k);
    end
  end
`else
  // Silent build: no simulation messages.
`endif

endmodule
